// File: rtl/dram_if_pkg.sv
// Shared widths and FSM encoding for the strobed-subblock DRAM port.
package dram_if_pkg;

    localparam int unsigned DADDR_BITS    = 32;
    localparam int unsigned DL2_BLOCK     = 512;
    localparam int unsigned DL2_SUBBLOCKS = 4;
    localparam int unsigned DL2_SUB_LOG2  = 2;

    typedef enum logic [2:0] {
        StIdle,
        StRdIssue,
        StRdCollect,
        StWrWait,
        StWrBeats,
        StResp
    } dram_state_e;

endpackage

// File: rtl/dram_beat_asm.sv
// Read-beat assembly buffer with per-slot mask and duplicate detection,
// plus the write-side subblock selector.
module dram_beat_asm
    import dram_if_pkg::*;
#(
    parameter int unsigned SUBBLOCKS = DL2_SUBBLOCKS,
    parameter int unsigned SUB_LOG2  = DL2_SUB_LOG2,
    parameter int unsigned SUB_BITS  = DL2_BLOCK / DL2_SUBBLOCKS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          beat_valid,
    input  logic [SUB_LOG2-1:0]           beat_idx,
    input  logic [SUB_BITS-1:0]           beat_data,
    output logic [SUBBLOCKS*SUB_BITS-1:0] asm_block,
    output logic                          complete,
    output logic                          dup_beat,
    input  logic [SUBBLOCKS*SUB_BITS-1:0] wr_block,
    input  logic [SUB_LOG2-1:0]           wr_idx,
    output logic [SUB_BITS-1:0]           wr_sub
);

    logic [SUBBLOCKS-1:0]               mask_q, mask_d;
    logic [SUBBLOCKS-1:0][SUB_BITS-1:0] buf_q, buf_d;
    logic [SUBBLOCKS-1:0][SUB_BITS-1:0] wr_arr;

    always_comb begin
        mask_d = mask_q;
        buf_d  = buf_q;
        if (clear) begin
            mask_d = '0;
        end else if (beat_valid) begin
            mask_d[beat_idx] = 1'b1;
            buf_d[beat_idx]  = beat_data;
        end
    end

    // Completion looks at the mask including the current beat so the
    // response can be registered in the same cycle as the last beat.
    assign complete  = beat_valid && !clear && (&mask_d);
    assign dup_beat  = beat_valid && mask_q[beat_idx];
    assign asm_block = buf_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
            buf_q  <= '0;
        end else begin
            mask_q <= mask_d;
            buf_q  <= buf_d;
        end
    end

    assign wr_arr = wr_block;
    assign wr_sub = wr_arr[wr_idx];

endmodule

// File: rtl/dram_port_master.sv
// Block-level initiator for the strobed-subblock DRAM interface: one read or
// write block in flight, all bus and response outputs registered.
module dram_port_master
    import dram_if_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = DADDR_BITS,
    parameter int unsigned BLOCK_BITS = DL2_BLOCK,
    parameter int unsigned SUBBLOCKS  = DL2_SUBBLOCKS,
    parameter int unsigned SUB_LOG2   = DL2_SUB_LOG2,
    localparam int unsigned SUB_BITS  = BLOCK_BITS / SUBBLOCKS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_BITS-1:0]  req_addr,
    input  logic [BLOCK_BITS-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [BLOCK_BITS-1:0] resp_rdata,
    output logic                  proto_err,
    output logic [ADDR_BITS-1:0]  addr,
    output logic                  en,
    output logic                  we,
    output logic [SUB_LOG2-1:0]   dinDstrobe,
    output logic [SUB_BITS-1:0]   din,
    input  logic [SUB_LOG2-1:0]   doutDstrobe,
    input  logic [SUB_BITS-1:0]   dout,
    input  logic                  dready,
    input  logic                  accR,
    input  logic                  accW
);

    dram_state_e           state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  en_q, en_d;
    logic                  we_q, we_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  proto_err_q, proto_err_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [BLOCK_BITS-1:0] wdata_q, wdata_d;
    logic [BLOCK_BITS-1:0] rdata_q, rdata_d;
    logic [SUB_LOG2-1:0]   k_q, k_d;
    logic [SUB_BITS-1:0]   din_q, din_d;

    logic                  asm_clear, beat_valid, complete, dup_beat;
    logic                  last_beat, wr_start, wr_step;
    logic [BLOCK_BITS-1:0] asm_block, wr_block;
    logic [SUB_BITS-1:0]   wr_sub;

    assign asm_clear  = (state_q == StIdle) && req_valid;
    assign beat_valid = (state_q == StRdCollect) && dready;
    assign last_beat  = k_q == SUB_LOG2'(SUBBLOCKS - 1);
    assign wr_start   = ((state_q == StIdle) && req_valid && req_we && accW) ||
                        ((state_q == StWrWait) && accW);
    assign wr_step    = (state_q == StWrBeats) && !last_beat;
    // Subblock 0 must come straight from the request when writing on acceptance.
    assign wr_block   = (state_q == StIdle) ? req_wdata : wdata_q;

    always_comb begin
        k_d = k_q;
        if (wr_start) begin
            k_d = '0;
        end else if (wr_step) begin
            k_d = k_q + SUB_LOG2'(1);
        end
    end

    dram_beat_asm #(
        .SUBBLOCKS (SUBBLOCKS),
        .SUB_LOG2  (SUB_LOG2),
        .SUB_BITS  (SUB_BITS)
    ) u_beat_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .beat_valid (beat_valid),
        .beat_idx   (doutDstrobe),
        .beat_data  (dout),
        .asm_block  (asm_block),
        .complete   (complete),
        .dup_beat   (dup_beat),
        .wr_block   (wr_block),
        .wr_idx     (k_d),
        .wr_sub     (wr_sub)
    );

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        en_d         = 1'b0;
        we_d         = 1'b0;
        resp_valid_d = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        din_d        = din_q;
        rdata_d      = rdata_q;
        proto_err_d  = proto_err_q | dup_beat | (dready && (state_q != StRdCollect));

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    req_ready_d = 1'b0;
                    if (req_we) begin
                        if (accW) begin
                            state_d = StWrBeats;
                            we_d    = 1'b1;
                            din_d   = wr_sub;
                        end else begin
                            state_d = StWrWait;
                        end
                    end else if (accR) begin
                        state_d = StRdCollect;
                        en_d    = 1'b1;
                    end else begin
                        state_d = StRdIssue;
                    end
                end
            end
            StRdIssue: begin
                if (accR) begin
                    state_d = StRdCollect;
                    en_d    = 1'b1;
                end
            end
            StRdCollect: begin
                if (complete) begin
                    rdata_d      = asm_block;
                    resp_valid_d = 1'b1;
                    state_d      = StResp;
                end
            end
            StWrWait: begin
                if (accW) begin
                    state_d = StWrBeats;
                    we_d    = 1'b1;
                    din_d   = wr_sub;
                end
            end
            StWrBeats: begin
                if (last_beat) begin
                    resp_valid_d = 1'b1;
                    state_d      = StResp;
                end else begin
                    we_d  = 1'b1;
                    din_d = wr_sub;
                end
            end
            StResp: begin
                state_d     = StIdle;
                req_ready_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            req_ready_q  <= 1'b1;
            en_q         <= 1'b0;
            we_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            proto_err_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            k_q          <= '0;
            din_q        <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            en_q         <= en_d;
            we_q         <= we_d;
            resp_valid_q <= resp_valid_d;
            proto_err_q  <= proto_err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            k_q          <= k_d;
            din_q        <= din_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign en         = en_q;
    assign we         = we_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign proto_err  = proto_err_q;
    assign addr       = addr_q;
    assign dinDstrobe = k_q;
    assign din        = din_q;

endmodule

// File: tb/tb_dram_port_master.sv
// Directed bench for dram_port_master with a latency-5 DRAM responder stub.
module tb_dram_port_master;

    localparam int unsigned AB = 32;
    localparam int unsigned BB = 128;
    localparam int unsigned SN = 4;
    localparam int unsigned SL = 2;
    localparam int unsigned SW = 32;

    localparam logic [BB-1:0] W1 = 128'h44443333_22221111_DEADBEEF_00C0FFEE;
    localparam logic [BB-1:0] W2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [BB-1:0] W3 = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid, req_ready, req_we;
    logic [AB-1:0] req_addr;
    logic [BB-1:0] req_wdata, resp_rdata;
    logic          resp_valid, proto_err, en, we;
    logic [AB-1:0] addr;
    logic [SL-1:0] dinDstrobe;
    logic [SW-1:0] din;
    logic [SL-1:0] doutDstrobe = '0;
    logic [SW-1:0] dout = '0;
    logic          dready = 1'b0;
    logic          accR, accW;

    dram_port_master #(
        .ADDR_BITS  (AB),
        .BLOCK_BITS (BB),
        .SUBBLOCKS  (SN),
        .SUB_LOG2   (SL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .proto_err   (proto_err),
        .addr        (addr),
        .en          (en),
        .we          (we),
        .dinDstrobe  (dinDstrobe),
        .din         (din),
        .doutDstrobe (doutDstrobe),
        .dout        (dout),
        .dready      (dready),
        .accR        (accR),
        .accW        (accW)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int trans_id = 0;
    int mon_id = 0;
    int issue_cyc = 0;
    logic [AB-1:0] exp_addr = '0;
    int stray_req = 0;
    int stray_done = 0;
    int rd_order [8];
    int rd_n = 4;

    int en_cnt, en_first, we_cnt, we_first, we_last, resp_cnt, resp_cyc;
    logic [7:0]    seq;
    logic [SW-1:0] din_first;
    logic          addr_bad, overlap;
    logic [SW-1:0] mem [longint];
    int sch_cyc [$];
    int sch_idx [$];

    // Transaction monitor and DRAM responder, both evaluated away from posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (trans_id != mon_id) begin
                mon_id = trans_id;
                en_cnt = 0; en_first = -1; we_cnt = 0; we_first = -1; we_last = -1;
                resp_cnt = 0; resp_cyc = -1; seq = '0; din_first = '0;
                addr_bad = 1'b0; overlap = 1'b0;
            end
            dready = 1'b0;
            doutDstrobe = '0;
            dout = '0;
            if (reset) begin
                sch_cyc.delete();
                sch_idx.delete();
            end else begin
                if (cyc > issue_cyc && resp_cnt == 0 && addr !== exp_addr) addr_bad = 1'b1;
                if (en && we) overlap = 1'b1;
                if (en) begin
                    en_cnt++;
                    if (en_cnt == 1) en_first = cyc;
                    for (int j = 0; j < rd_n; j++) begin
                        sch_cyc.push_back(cyc + 5 + j);
                        sch_idx.push_back(rd_order[j]);
                    end
                end
                if (we) begin
                    if (we_cnt == 0) begin
                        we_first = cyc;
                        din_first = din;
                    end
                    if (we_cnt < 4) seq[2*we_cnt +: 2] = dinDstrobe;
                    we_cnt++;
                    we_last = cyc;
                    mem[longint'({addr, dinDstrobe})] = din;
                end
                if (resp_valid) begin
                    resp_cnt++;
                    resp_cyc = cyc;
                end
                if (stray_req != stray_done) begin
                    stray_done = stray_req;
                    dready = 1'b1;
                end else if (sch_cyc.size() > 0 && sch_cyc[0] == cyc) begin
                    dready = 1'b1;
                    doutDstrobe = SL'(sch_idx[0]);
                    dout = mem.exists(longint'({addr, doutDstrobe})) ?
                           mem[longint'({addr, doutDstrobe})] : '0;
                    void'(sch_cyc.pop_front());
                    void'(sch_idx.pop_front());
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string p);
        check_eq({p, "_req_ready"}, 128'(req_ready), 128'(1));
        check_eq({p, "_resp_valid"}, 128'(resp_valid), 128'(0));
        check_eq({p, "_en"}, 128'(en), 128'(0));
        check_eq({p, "_we"}, 128'(we), 128'(0));
        check_eq({p, "_proto_err"}, 128'(proto_err), 128'(0));
        check_eq({p, "_addr"}, 128'(addr), 128'(0));
        check_eq({p, "_dinDstrobe"}, 128'(dinDstrobe), 128'(0));
        check_eq({p, "_din"}, 128'(din), 128'(0));
        check_eq({p, "_resp_rdata"}, resp_rdata, 128'(0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Issue one request in the current cycle, hold accR/accW low for g cycles
    // starting at acceptance, then wait (bounded) for the response.
    task automatic run_req(input logic w, input logic [AB-1:0] a, input logic [BB-1:0] d,
                           input int g);
        trans_id++;
        issue_cyc = cyc;
        exp_addr = a;
        check_eq("ready_at_issue", 128'(req_ready), 128'(1));
        req_valid = 1'b1;
        req_we = w;
        req_addr = a;
        req_wdata = d;
        if (g > 0) begin
            if (w) accW = 1'b0;
            else accR = 1'b0;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 1; i < g; i++) begin
            @(posedge clk);
            #1;
        end
        accR = 1'b1;
        accW = 1'b1;
        for (int i = 0; i < 60 && resp_cnt == 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (resp_cnt == 0) check_eq("resp_timeout", 128'(resp_cnt), 128'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        accR = 1'b1; accW = 1'b1;
        rd_order = '{0, 1, 2, 3, 0, 0, 0, 0};
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_vals("por");

        // Plain write
        run_req(1'b1, 32'h8000, W1, 0);
        check_eq("wr_we_cnt", 128'(we_cnt), 128'(4));
        check_eq("wr_we_first", 128'(we_first), 128'(issue_cyc + 1));
        check_eq("wr_we_last", 128'(we_last), 128'(issue_cyc + 4));
        check_eq("wr_strobes", 128'(seq), 128'(8'hE4));
        check_eq("wr_din_first", 128'(din_first), 128'(32'h00C0FFEE));
        check_eq("wr_resp_cyc", 128'(resp_cyc), 128'(issue_cyc + 5));
        check_eq("wr_resp_cnt", 128'(resp_cnt), 128'(1));
        check_eq("wr_addr_stable", 128'(addr_bad), 128'(0));
        check_eq("wr_no_en", 128'(en_cnt), 128'(0));

        // Readback
        run_req(1'b0, 32'h8000, '0, 0);
        check_eq("rd_rdata", resp_rdata, W1);
        check_eq("rd_resp_cyc", 128'(resp_cyc), 128'(issue_cyc + 10));
        check_eq("rd_en_cnt", 128'(en_cnt), 128'(1));
        check_eq("rd_en_first", 128'(en_first), 128'(issue_cyc + 1));
        check_eq("rd_no_overlap", 128'(overlap), 128'(0));
        check_eq("rd_proto_err", 128'(proto_err), 128'(0));

        // accR / accW gating
        run_req(1'b0, 32'h8000, '0, 7);
        check_eq("gr_en_first", 128'(en_first), 128'(issue_cyc + 8));
        check_eq("gr_resp_cyc", 128'(resp_cyc), 128'(issue_cyc + 17));
        check_eq("gr_addr_stable", 128'(addr_bad), 128'(0));
        check_eq("gr_rdata", resp_rdata, W1);
        run_req(1'b1, 32'h9000, W2, 7);
        check_eq("gw_we_first", 128'(we_first), 128'(issue_cyc + 8));
        check_eq("gw_resp_cyc", 128'(resp_cyc), 128'(issue_cyc + 12));
        check_eq("gw_addr_stable", 128'(addr_bad), 128'(0));
        check_eq("gw_we_cnt", 128'(we_cnt), 128'(4));

        // Out-of-order beats
        rd_order = '{2, 0, 3, 1, 0, 0, 0, 0};
        run_req(1'b0, 32'h9000, '0, 0);
        check_eq("ooo_rdata", resp_rdata, W2);
        check_eq("ooo_resp_cyc", 128'(resp_cyc), 128'(issue_cyc + 10));
        check_eq("ooo_proto_err", 128'(proto_err), 128'(0));

        // Stray beat while idle, error must be sticky
        rd_order = '{0, 1, 2, 3, 0, 0, 0, 0};
        stray_req++;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_eq("stray_proto_err", 128'(proto_err), 128'(1));
        run_req(1'b0, 32'h8000, '0, 0);
        check_eq("stray_rdata", resp_rdata, W1);
        check_eq("stray_sticky", 128'(proto_err), 128'(1));
        do_reset();
        check_eq("stray_cleared", 128'(proto_err), 128'(0));

        // Duplicate strobe 1
        rd_order = '{1, 0, 1, 2, 3, 0, 0, 0};
        rd_n = 5;
        run_req(1'b0, 32'h9000, '0, 0);
        check_eq("dup_proto_err", 128'(proto_err), 128'(1));
        check_eq("dup_rdata", resp_rdata, W2);
        rd_order = '{0, 1, 2, 3, 0, 0, 0, 0};
        rd_n = 4;
        do_reset();

        // Reset during write beat 2
        trans_id++;
        issue_cyc = cyc;
        exp_addr = 32'hA000;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'hA000; req_wdata = W3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("abort_we", 128'(we), 128'(1));
        check_eq("abort_beat2", 128'(dinDstrobe), 128'(2));
        #2 reset = 1'b1;
        #1 check_reset_vals("abort");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (8) @(posedge clk);
        #1 check_eq("abort_no_resp", 128'(resp_cnt), 128'(0));
        run_req(1'b0, 32'h8000, '0, 0);
        check_eq("post_rdata", resp_rdata, W1);
        check_eq("post_resp_cyc", 128'(resp_cyc), 128'(issue_cyc + 10));
        check_eq("post_proto_err", 128'(proto_err), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
